// File: rtl/cpu_wb_pkg.sv
// Shared types for the CPU-side Wishbone arbiter: grant states, default bus
// widths and a request bundle used to mux the two masters onto the slave.
package cpu_wb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DEF_AW-1:0]     adr;
    logic [DEF_DW-1:0]     dat_w;
    logic [DEF_DW/8-1:0]   sel;
  } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Hung-access watchdog: counts stalled strobe cycles and pulses expire for one
// cycle when the count reaches TIMEOUT.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_r;

  // A cleared or ending cycle never expires, so ack always wins over err.
  assign expire = stb && !ack && !clr && (cnt_r == LIMIT);

  // Stall counter, restarted by any ack, idle strobe, grant change or expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || !stb || ack || expire) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/wb_ibus_dbus_arbiter.sv
// Round-robin, cycle-locked arbiter merging the instruction and data Wishbone
// masters onto one slave, with a watchdog that errors out hung accesses.
module wb_ibus_dbus_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mi_cyc,
  input  logic            mi_stb,
  input  logic            mi_we,
  input  logic [AW-1:0]   mi_adr,
  input  logic [DW-1:0]   mi_dat_w,
  input  logic [DW/8-1:0] mi_sel,
  output logic [DW-1:0]   mi_dat_r,
  output logic            mi_ack,
  output logic            mi_err,
  input  logic            md_cyc,
  input  logic            md_stb,
  input  logic            md_we,
  input  logic [AW-1:0]   md_adr,
  input  logic [DW-1:0]   md_dat_w,
  input  logic [DW/8-1:0] md_sel,
  output logic [DW-1:0]   md_dat_r,
  output logic            md_ack,
  output logic            md_err,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       last_gnt_r;
  wb_req_t    req_i_s;
  wb_req_t    req_d_s;
  wb_req_t    req_s;
  logic       wd_clr_s;
  logic       expire_s;

  // Widen both master requests into the shared bundle.
  always_comb begin
    req_i_s = {$bits(wb_req_t){1'b0}};
    req_d_s = {$bits(wb_req_t){1'b0}};
    req_i_s.cyc   = mi_cyc;
    req_i_s.stb   = mi_stb;
    req_i_s.we    = mi_we;
    req_i_s.adr   = DEF_AW'(mi_adr);
    req_i_s.dat_w = DEF_DW'(mi_dat_w);
    req_i_s.sel   = (DEF_DW/8)'(mi_sel);
    req_d_s.cyc   = md_cyc;
    req_d_s.stb   = md_stb;
    req_d_s.we    = md_we;
    req_d_s.adr   = DEF_AW'(md_adr);
    req_d_s.dat_w = DEF_DW'(md_dat_w);
    req_d_s.sel   = (DEF_DW/8)'(md_sel);
  end

  // Grant selection: a tie goes to the master that did not own the bus last.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mi_cyc && md_cyc) begin
          state_nxt_s = last_gnt_r ? GNT_I : GNT_D;
        end else if (mi_cyc) begin
          state_nxt_s = GNT_I;
        end else if (md_cyc) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_I: begin
        if (mi_cyc) begin
          state_nxt_s = GNT_I;
        end else if (md_cyc) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_D: begin
        if (md_cyc) begin
          state_nxt_s = GNT_D;
        end else if (mi_cyc) begin
          state_nxt_s = GNT_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant register; last_gnt records the owner only when it lets go.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == GNT_I && !mi_cyc) begin
        last_gnt_r <= 1'b0;
      end else if (state_r == GNT_D && !md_cyc) begin
        last_gnt_r <= 1'b1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  assign wd_clr_s = (state_nxt_s != state_r);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst),
    .stb    (req_s.stb),
    .ack    (s_ack),
    .clr    (wd_clr_s),
    .expire (expire_s)
  );

  // Slave mux and response routing; the waiting master simply stalls.
  always_comb begin
    req_s  = {$bits(wb_req_t){1'b0}};
    mi_ack = 1'b0;
    mi_err = 1'b0;
    md_ack = 1'b0;
    md_err = 1'b0;
    case (state_r)
      GNT_I: begin
        req_s  = req_i_s;
        mi_ack = s_ack;
        mi_err = expire_s;
      end
      GNT_D: begin
        req_s  = req_d_s;
        md_ack = s_ack;
        md_err = expire_s;
      end
      default: begin
        req_s = {$bits(wb_req_t){1'b0}};
      end
    endcase
  end

  assign s_cyc    = req_s.cyc;
  assign s_stb    = req_s.stb;
  assign s_we     = req_s.we;
  assign s_adr    = req_s.adr[AW-1:0];
  assign s_dat_w  = req_s.dat_w[DW-1:0];
  assign s_sel    = req_s.sel[DW/8-1:0];
  assign mi_dat_r = s_dat_r;
  assign md_dat_r = s_dat_r;

endmodule
